// File: rtl/bmem_responder.sv
// Burst-memory responder: DEPTH lines of 4x64-bit words, 4-beat write bursts and
// fixed-latency 4-beat read bursts. Define BMEM_RESPONDER_JITTER_EN to add 0..3 LFSR-driven extra read cycles.
module bmem_responder #(
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned READ_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bmem_addr,
  input  logic        bmem_read,
  input  logic        bmem_write,
  input  logic [63:0] bmem_wdata,
  output logic        bmem_ready,
  output logic [31:0] bmem_raddr,
  output logic [63:0] bmem_rdata,
  output logic        bmem_rvalid,
  output logic        bmem_err
);

  localparam int unsigned BEAT_W = 64;
  localparam int unsigned BEATS  = DATA_WIDTH / BEAT_W;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LAT_W  = $clog2(READ_LATENCY + 4) + 1;

  typedef enum logic [1:0] {IDLE, WRITE, RWAIT, RBURST} state_t;

  logic [BEATS-1:0][BEAT_W-1:0] mem [DEPTH];

  state_t           state;
  logic [1:0]       beat_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic [LAT_W-1:0] lat_total;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] addr_idx;
  logic [31:0]      rd_addr;

  logic             we;
  logic [IDX_W-1:0] we_idx;
  logic [1:0]       we_word;

  assign addr_idx   = bmem_addr[5 +: IDX_W];
  assign bmem_ready = (state == IDLE);

`ifdef BMEM_RESPONDER_JITTER_EN
  logic [7:0] lfsr;

  // x^8+x^6+x^5+x^4+1 Fibonacci LFSR, free-running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= 8'hA5;
    else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign lat_total = LAT_W'(READ_LATENCY) + LAT_W'(lfsr[1:0]);
`else
  assign lat_total = LAT_W'(READ_LATENCY);
`endif

  // Word write enable: first beat from IDLE, continuation beats in WRITE
  always_comb begin
    we      = 1'b0;
    we_idx  = idx;
    we_word = beat_cnt;
    if (state == IDLE && bmem_write) begin
      we      = 1'b1;
      we_idx  = addr_idx;
      we_word = 2'd0;
    end else if (state == WRITE && bmem_write) begin
      we = 1'b1;
    end
  end

  // Storage has no reset so contents survive rst
  always_ff @(posedge clk) begin
    if (we && !rst) mem[we_idx][we_word] <= bmem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      beat_cnt    <= 2'd0;
      lat_cnt     <= '0;
      idx         <= '0;
      rd_addr     <= 32'd0;
      bmem_raddr  <= 32'd0;
      bmem_rdata  <= 64'd0;
      bmem_rvalid <= 1'b0;
      bmem_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bmem_write) begin
            idx      <= addr_idx;
            beat_cnt <= 2'd1;
            state    <= WRITE;
            if (bmem_read) bmem_err <= 1'b1;
          end else if (bmem_read) begin
            idx     <= addr_idx;
            rd_addr <= bmem_addr;
            if (lat_total == LAT_W'(1)) begin
              state       <= RBURST;
              beat_cnt    <= 2'd0;
              bmem_rvalid <= 1'b1;
              bmem_rdata  <= mem[addr_idx][0];
              bmem_raddr  <= bmem_addr;
            end else begin
              state   <= RWAIT;
              lat_cnt <= lat_total - LAT_W'(1);
            end
          end
        end
        WRITE: begin
          if (bmem_read) bmem_err <= 1'b1;
          if (bmem_write) begin
            beat_cnt <= 2'(beat_cnt + 2'd1);
            if (beat_cnt == 2'd3) state <= IDLE;
          end else begin
            // Short burst: keep the beats already written
            bmem_err <= 1'b1;
            beat_cnt <= 2'd0;
            state    <= IDLE;
          end
        end
        RWAIT: begin
          if (bmem_read || bmem_write) bmem_err <= 1'b1;
          if (lat_cnt == LAT_W'(1)) begin
            state       <= RBURST;
            beat_cnt    <= 2'd0;
            bmem_rvalid <= 1'b1;
            bmem_rdata  <= mem[idx][0];
            bmem_raddr  <= rd_addr;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        RBURST: begin
          if (bmem_read || bmem_write) bmem_err <= 1'b1;
          if (beat_cnt == 2'd3) begin
            state       <= IDLE;
            beat_cnt    <= 2'd0;
            bmem_rvalid <= 1'b0;
          end else begin
            beat_cnt   <= 2'(beat_cnt + 2'd1);
            bmem_rdata <= mem[idx][2'(beat_cnt + 2'd1)];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bmem_responder.sv
// Scoreboard bench for bmem_responder: driver pushes expected read beats, a negedge monitor checks them.
module tb_bmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned RL    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_write;
  logic [63:0] bmem_wdata;
  logic        bmem_ready;
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;
  logic        bmem_err;

  bmem_responder #(.DATA_WIDTH(256), .DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk        (clk),
    .rst        (rst),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_raddr (bmem_raddr),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid),
    .bmem_err   (bmem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [31:0] a;
    int          c;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model [DEPTH][4];
  int          cyc   = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every rvalid beat must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && bmem_rvalid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'(bmem_rvalid), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rdata", bmem_rdata, e.d);
        check("raddr", 64'(bmem_raddr), 64'(e.a));
`ifndef BMEM_RESPONDER_JITTER_EN
        check("beat_cycle", 64'(cyc), 64'(e.c));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 5) % DEPTH);
  endfunction

  task automatic wr_burst(input logic [31:0] a, input logic [63:0] b0, input logic [63:0] b1,
                          input logic [63:0] b2, input logic [63:0] b3, input int nbeats,
                          input logic with_read);
    logic [63:0] bt [4];
    bt[0] = b0; bt[1] = b1; bt[2] = b2; bt[3] = b3;
    for (int k = 0; k < nbeats; k++) begin
      bmem_write = 1'b1;
      bmem_read  = (k == 0) ? with_read : 1'b0;
      bmem_addr  = (k == 0) ? a : 32'hDEAD_BEEF;
      bmem_wdata = bt[k];
      model[line_of(a)][k] = bt[k];
      tick();
      if (k < 3) check("wr_busy_ready", 64'(bmem_ready), 64'd0);
    end
    bmem_write = 1'b0;
    bmem_read  = 1'b0;
    bmem_addr  = 32'd0;
    if (nbeats < 4) tick();
    check("wr_end_ready", 64'(bmem_ready), 64'd1);
  endtask

  // Issue a read, push all four beats, wait for ready to return
  task automatic rd(input logic [31:0] a);
    int t0;
    int n;
    t0 = cyc;
    bmem_read = 1'b1;
    bmem_addr = a;
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      e.d = model[line_of(a)][k];
      e.a = a;
      e.c = t0 + int'(RL) + k;
      exp_q.push_back(e);
    end
    tick();
    bmem_read = 1'b0;
    bmem_addr = 32'd0;
    check("rd_busy_ready", 64'(bmem_ready), 64'd0);
    n = 0;
    while (!bmem_ready && n < 40) begin
      tick();
      n++;
    end
    if (!bmem_ready) check("rd_timeout", 64'(bmem_ready), 64'd1);
`ifndef BMEM_RESPONDER_JITTER_EN
    check("rd_ready_cycle", 64'(cyc), 64'(t0 + int'(RL) + 4));
`endif
    check("rd_beats_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int t0;
    rst        = 1'b1;
    bmem_addr  = 32'd0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = 64'd0;
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 3; i++) begin
      check("idle_ready", 64'(bmem_ready), 64'd1);
      check("idle_rvalid", 64'(bmem_rvalid), 64'd0);
      check("idle_err", 64'(bmem_err), 64'd0);
      tick();
    end
    check("reset_rdata", bmem_rdata, 64'd0);
    check("reset_raddr", 64'(bmem_raddr), 64'd0);

    // Write 0x40 then read it back at T+5
    wr_burst(32'h40, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
             64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 4, 1'b0);
    tick();
    rd(32'h40);
    check("rdata_hold", bmem_rdata, 64'h4444_4444_4444_4444);

    // Aliasing and ignored low address bits
    rd(32'h40 + DEPTH * 32);
    rd(32'h5F);

    // Known contents for line 0x80
    wr_burst(32'h80, 64'hA0A0_0000_0000_0000, 64'hA1A1_0000_0000_0001,
             64'hA2A2_0000_0000_0002, 64'hA3A3_0000_0000_0003, 4, 1'b0);
    rd(32'h80);
    check("err_clean", 64'(bmem_err), 64'd0);

    // Reset during beat 1 of a read
    t0 = cyc;
    begin
      exp_t e;
      e.d = model[line_of(32'h40)][0];
      e.a = 32'h40;
      e.c = t0 + int'(RL);
      exp_q.push_back(e);
    end
    bmem_read = 1'b1;
    bmem_addr = 32'h40;
    tick();
    bmem_read = 1'b0;
    while (cyc < t0 + int'(RL) + 1 && cyc < t0 + 40) tick();
    rst = 1'b1;
    #1;
    check("rst_rvalid_async", 64'(bmem_rvalid), 64'd0);
    check("rst_beat0_seen", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", 64'(bmem_ready), 64'd1);
    check("rst_err", 64'(bmem_err), 64'd0);
    rd(32'h40);

    // Read and write together in IDLE: write wins, no beats, err sticks
    wr_burst(32'hC0, 64'hC0C0_C0C0_0000_0000, 64'hC1C1_C1C1_0000_0001,
             64'hC2C2_C2C2_0000_0002, 64'hC3C3_C3C3_0000_0003, 4, 1'b1);
    for (int i = 0; i < 8; i++) tick();
    check("rw_err", 64'(bmem_err), 64'd1);
    rd(32'hC0);
    check("rw_err_sticky", 64'(bmem_err), 64'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("err_cleared", 64'(bmem_err), 64'd0);

    // Short write burst: 2 beats kept, old words 2-3 remain
    wr_burst(32'h80, 64'hB0B0_B0B0_B0B0_B0B0, 64'hB1B1_B1B1_B1B1_B1B1,
             64'd0, 64'd0, 2, 1'b0);
    check("abort_err", 64'(bmem_err), 64'd1);
    check("abort_word2_model", model[line_of(32'h80)][2], 64'hA2A2_0000_0000_0002);
    rd(32'h80);
    tick();
    check("final_queue", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
